// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared types for the split-half regfile writeback path.
// Load size/extension encodings plus writeback FSM and source enums.
package regfile_wb_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    SIZE_W,
    SIZE_H,
    SIZE_B,
    SIZE_BIT
  } cs_size;

  typedef enum logic {
    EXT_Z,
    EXT_S
  } cs_ext;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_LO,
    WB_HI
  } wb_state_e;

  typedef enum logic {
    SRC_ALU,
    SRC_LSU
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_ext.sv
// Size/extension formatter: right-aligned raw data to a 32-bit word.
// Shared by the writeback controller and the load/store path.
module regfile_wb_ext
  import regfile_wb_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  cs_size          size_i,
  input  cs_ext           ext_i,
  output logic [XLEN-1:0] word_o
);

  logic sx_h;
  logic sx_b;

  assign sx_h = (ext_i == EXT_S) && data_i[15];
  assign sx_b = (ext_i == EXT_S) && data_i[7];

  always_comb begin
    word_o = data_i;
    unique case (size_i)
      SIZE_W:   word_o = data_i;
      SIZE_H:   word_o = {{16{sx_h}}, data_i[15:0]};
      SIZE_B:   word_o = {{24{sx_b}}, data_i[7:0]};
      SIZE_BIT: word_o = {31'b0, data_i[0]};
    endcase
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback arbiter + two-phase half-write sequencer for the regfile.
// Define REGFILE_WB_RR_EN for round-robin grant instead of LSU priority.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [4:0]        alu_rd_i,
  input  logic [XLEN-1:0]   alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [4:0]        lsu_rd_i,
  input  logic [XLEN-1:0]   lsu_data_i,
  input  cs_size            lsu_size_i,
  input  cs_ext             lsu_ext_i,
  output logic              rf_write_o,
  output logic [4:0]        rf_rd_o,
  output logic              rf_h_sel_o,
  output logic [HALF_W-1:0] rf_data_o,
  output logic              second_cycle_o,
  output logic              pend_valid_o,
  output logic [4:0]        pend_rd_o
);

  wb_state_e       state_q, state_d;
  logic [XLEN-1:0] word_q, word_d;
  logic [4:0]      rd_q, rd_d;

  logic            win;
  logic            grant_lsu;
  logic            accept;
  logic [4:0]      acc_rd;
  logic [XLEN-1:0] acc_data;
  cs_size          acc_size;
  cs_ext           acc_ext;
  logic [XLEN-1:0] fmt_word;

  assign win = (state_q == WB_IDLE) || (state_q == WB_HI);

`ifdef REGFILE_WB_RR_EN
  wb_src_e rr_last_q, rr_last_d;

  // Under contention the source that did not win last time gets the grant.
  assign grant_lsu = lsu_valid_i &&
                     (!alu_valid_i || rr_last_q == SRC_ALU);

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept)
      rr_last_d = grant_lsu ? SRC_LSU : SRC_ALU;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= SRC_ALU;
    else        rr_last_q <= rr_last_d;
  end
`else
  assign grant_lsu = lsu_valid_i;
`endif

  assign lsu_ready_o = win && grant_lsu;
  assign alu_ready_o = win && alu_valid_i && !grant_lsu;
  assign accept      = lsu_ready_o || alu_ready_o;

  assign acc_rd   = grant_lsu ? lsu_rd_i   : alu_rd_i;
  assign acc_data = grant_lsu ? lsu_data_i : alu_data_i;
  assign acc_size = grant_lsu ? lsu_size_i : SIZE_W;
  assign acc_ext  = grant_lsu ? lsu_ext_i  : EXT_Z;

  regfile_wb_ext u_ext (
    .data_i (acc_data),
    .size_i (acc_size),
    .ext_i  (acc_ext),
    .word_o (fmt_word)
  );

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    rd_d           = rd_q;
    rf_write_o     = 1'b0;
    rf_h_sel_o     = 1'b0;
    rf_data_o      = '0;
    second_cycle_o = 1'b0;

    if (accept) begin
      word_d = fmt_word;
      rd_d   = acc_rd;
    end

    unique case (state_q)
      WB_IDLE: begin
        if (accept)
          state_d = (acc_rd != 5'd0) ? WB_LO : WB_IDLE;
      end
      WB_LO: begin
        rf_write_o = 1'b1;
        rf_data_o  = word_q[HALF_W-1:0];
        state_d    = WB_HI;
      end
      WB_HI: begin
        rf_write_o     = 1'b1;
        rf_h_sel_o     = 1'b1;
        rf_data_o      = word_q[XLEN-1:HALF_W];
        second_cycle_o = 1'b1;
        if (accept && acc_rd != 5'd0) state_d = WB_LO;
        else                          state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  assign rf_rd_o      = rd_q;
  assign pend_rd_o    = rd_q;
  assign pend_valid_o = (state_q == WB_LO) || (state_q == WB_HI);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
      word_q  <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: formatting, arbitration, rd=0, reset.
// Expectations follow REGFILE_WB_RR_EN when it is defined.
module tb_regfile_wb_ctrl;
  import regfile_wb_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid_i;
  logic        alu_ready_o;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        lsu_valid_i;
  logic        lsu_ready_o;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  cs_size      lsu_size_i;
  cs_ext       lsu_ext_i;
  logic        rf_write_o;
  logic [4:0]  rf_rd_o;
  logic        rf_h_sel_o;
  logic [15:0] rf_data_o;
  logic        second_cycle_o;
  logic        pend_valid_o;
  logic [4:0]  pend_rd_o;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_wb_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alu_valid_i    (alu_valid_i),
    .alu_ready_o    (alu_ready_o),
    .alu_rd_i       (alu_rd_i),
    .alu_data_i     (alu_data_i),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_ready_o    (lsu_ready_o),
    .lsu_rd_i       (lsu_rd_i),
    .lsu_data_i     (lsu_data_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_ext_i      (lsu_ext_i),
    .rf_write_o     (rf_write_o),
    .rf_rd_o        (rf_rd_o),
    .rf_h_sel_o     (rf_h_sel_o),
    .rf_data_o      (rf_data_o),
    .second_cycle_o (second_cycle_o),
    .pend_valid_o   (pend_valid_o),
    .pend_rd_o      (pend_rd_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Checks the low-half then high-half write, then the return to idle.
  task automatic expect_write(input string tag, input logic [4:0] rd,
                              input logic [31:0] word);
    @(negedge clk);
    chk({tag, " lo.we"}, 32'(rf_write_o), 32'd1);
    chk({tag, " lo.sel"}, 32'(rf_h_sel_o), 32'd0);
    chk({tag, " lo.data"}, 32'(rf_data_o), 32'(word[15:0]));
    chk({tag, " lo.rd"}, 32'(rf_rd_o), 32'(rd));
    chk({tag, " lo.pend"}, {27'b0, pend_rd_o}, 32'(rd));
    chk({tag, " lo.2nd"}, 32'(second_cycle_o), 32'd0);
    @(negedge clk);
    chk({tag, " hi.we"}, 32'(rf_write_o), 32'd1);
    chk({tag, " hi.sel"}, 32'(rf_h_sel_o), 32'd1);
    chk({tag, " hi.data"}, 32'(rf_data_o), 32'(word[31:16]));
    chk({tag, " hi.2nd"}, 32'(second_cycle_o), 32'd1);
    chk({tag, " hi.pend"}, 32'(pend_valid_o), 32'd1);
    @(negedge clk);
    chk({tag, " idle.we"}, 32'(rf_write_o), 32'd0);
    chk({tag, " idle.data"}, 32'(rf_data_o), 32'd0);
    chk({tag, " idle.pend"}, 32'(pend_valid_o), 32'd0);
  endtask

  task automatic lsu_req(input string tag, input logic [4:0] rd,
                         input logic [31:0] data, input cs_size sz,
                         input cs_ext ext, input logic [31:0] word);
    lsu_valid_i = 1'b1;
    lsu_rd_i    = rd;
    lsu_data_i  = data;
    lsu_size_i  = sz;
    lsu_ext_i   = ext;
    #1;
    chk({tag, " ready"}, 32'(lsu_ready_o), 32'd1);
    @(posedge clk);
    #1 lsu_valid_i = 1'b0;
    expect_write(tag, rd, word);
  endtask

  initial begin
    rst_n       = 1'b0;
    alu_valid_i = 1'b0;
    alu_rd_i    = '0;
    alu_data_i  = '0;
    lsu_valid_i = 1'b0;
    lsu_rd_i    = '0;
    lsu_data_i  = '0;
    lsu_size_i  = SIZE_W;
    lsu_ext_i   = EXT_Z;

    repeat (2) @(negedge clk);
    chk("rst.we", 32'(rf_write_o), 32'd0);
    chk("rst.data", 32'(rf_data_o), 32'd0);
    chk("rst.pend", 32'(pend_valid_o), 32'd0);
    chk("rst.pend_rd", {27'b0, pend_rd_o}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ALU-only write
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd5;
    alu_data_i  = 32'h1234_5678;
    #1;
    chk("alu.ready", 32'(alu_ready_o), 32'd1);
    chk("alu.lsu_ready", 32'(lsu_ready_o), 32'd0);
    @(posedge clk);
    #1 alu_valid_i = 1'b0;
    expect_write("alu", 5'd5, 32'h1234_5678);

    // Load formatting
    lsu_req("lb_s", 5'd6, 32'h0000_00F0, SIZE_B, EXT_S, 32'hFFFF_FFF0);
    lsu_req("lb_z", 5'd6, 32'h0000_00F0, SIZE_B, EXT_Z, 32'h0000_00F0);
    lsu_req("lh_s", 5'd7, 32'h0000_8001, SIZE_H, EXT_S, 32'hFFFF_8001);
    lsu_req("lbit", 5'd8, 32'hFFFF_FFFF, SIZE_BIT, EXT_S, 32'h0000_0001);

    // Contention: both requesters held valid
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd1;
    alu_data_i  = 32'hAAAA_5555;
    lsu_valid_i = 1'b1;
    lsu_rd_i    = 5'd2;
    lsu_data_i  = 32'h0000_BEEF;
    lsu_size_i  = SIZE_W;
    lsu_ext_i   = EXT_Z;
    #1;
    chk("cont1.lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("cont1.alu_ready", 32'(alu_ready_o), 32'd0);
    @(negedge clk);
    chk("cont1.lo_rd", 32'(rf_rd_o), 32'd2);
    chk("cont1.lo_data", 32'(rf_data_o), 32'h0000_BEEF);
    chk("cont.lo_lsu_ready", 32'(lsu_ready_o), 32'd0);
    chk("cont.lo_alu_ready", 32'(alu_ready_o), 32'd0);
    @(negedge clk);
    chk("cont1.hi_2nd", 32'(second_cycle_o), 32'd1);
`ifdef REGFILE_WB_RR_EN
    chk("cont2.lsu_ready", 32'(lsu_ready_o), 32'd0);
    chk("cont2.alu_ready", 32'(alu_ready_o), 32'd1);
    @(negedge clk);
    chk("cont2.lo_we", 32'(rf_write_o), 32'd1);
    chk("cont2.lo_rd", 32'(rf_rd_o), 32'd1);
    chk("cont2.lo_data", 32'(rf_data_o), 32'h0000_5555);
    @(negedge clk);
    chk("cont2.hi_data", 32'(rf_data_o), 32'h0000_AAAA);
    chk("cont3.lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("cont3.alu_ready", 32'(alu_ready_o), 32'd0);
`else
    chk("cont2.lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("cont2.alu_ready", 32'(alu_ready_o), 32'd0);
    @(negedge clk);
    chk("cont2.lo_we", 32'(rf_write_o), 32'd1);
    chk("cont2.lo_rd", 32'(rf_rd_o), 32'd2);
    chk("cont2.lo_data", 32'(rf_data_o), 32'h0000_BEEF);
    @(negedge clk);
    chk("cont3.lsu_ready", 32'(lsu_ready_o), 32'd1);
    chk("cont3.alu_ready", 32'(alu_ready_o), 32'd0);
`endif
    alu_valid_i = 1'b0;
    lsu_valid_i = 1'b0;
    @(negedge clk);
    chk("cont.end_idle", 32'(rf_write_o), 32'd0);

    // rd=0 request is consumed without any write
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd0;
    alu_data_i  = 32'hDEAD_BEEF;
    #1;
    chk("rd0.ready", 32'(alu_ready_o), 32'd1);
    @(negedge clk);
    chk("rd0.we", 32'(rf_write_o), 32'd0);
    chk("rd0.pend", 32'(pend_valid_o), 32'd0);
    alu_rd_i   = 5'd7;
    alu_data_i = 32'h0000_CAFE;
    #1;
    chk("rd0.next_ready", 32'(alu_ready_o), 32'd1);
    @(posedge clk);
    #1 alu_valid_i = 1'b0;
    expect_write("after_rd0", 5'd7, 32'h0000_CAFE);

    // Reset asserted during the low-half write
    alu_valid_i = 1'b1;
    alu_rd_i    = 5'd9;
    alu_data_i  = 32'h1111_2222;
    @(posedge clk);
    #1 alu_valid_i = 1'b0;
    @(negedge clk);
    chk("rstlo.we_before", 32'(rf_write_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstlo.we", 32'(rf_write_o), 32'd0);
    chk("rstlo.data", 32'(rf_data_o), 32'd0);
    chk("rstlo.pend", 32'(pend_valid_o), 32'd0);
    chk("rstlo.2nd", 32'(second_cycle_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstlo.no_hi_we", 32'(rf_write_o), 32'd0);
    chk("rstlo.no_hi_sel", 32'(rf_h_sel_o), 32'd0);
    chk("rstlo.pend_after", 32'(pend_valid_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
